// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the bittyCore memory-access stage.
// Holds the load/store aluop codes, the LSU state encoding and small
// op-decoding helpers used by mem_lsu and mem_lsu_align.
package mem_lsu_pkg;

  localparam logic [7:0] EXE_LB  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU = 8'b1110_0101;
  localparam logic [7:0] EXE_SB  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW  = 8'b1110_1011;

  localparam int BUS_BE_W = 4;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_BUSY  = 2'd1,
    LSU_DONE  = 2'd2,
    LSU_ABORT = 2'd3
  } lsu_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB) || (op == EXE_LH) || (op == EXE_LW) ||
           (op == EXE_LBU) || (op == EXE_LHU);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = (op == EXE_LH) || (op == EXE_LHU) || (op == EXE_SH);
    word_op = (op == EXE_LW) || (op == EXE_SW);
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment for the LSU, purely combinational.
// Store ops: be_o = byte enables, data_o = store data replicated across lanes.
// Load ops:  be_o = 4'b1111 (full-word read), data_o = extracted and
//            sign/zero-extended byte/halfword, or the whole word for LW.
// Other ops: be_o = 4'b1111, data_o = data_i.
// Ports: op (aluop), addr_lo (address bits [1:0]), data_i (rs2 or read word).
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]          op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         data_i,
  output logic [BUS_BE_W-1:0] be_o,
  output logic [31:0]         data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    half_sel = addr_lo[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    be_o   = 4'b1111;
    data_o = data_i;
    case (op)
      EXE_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU: data_o = {24'd0, byte_sel};
      EXE_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      EXE_LHU: data_o = {16'd0, half_sel};
      EXE_LW:  data_o = data_i;
      EXE_SB: begin
        be_o   = 4'b0001 << addr_lo;
        data_o = {4{data_i[7:0]}};
      end
      EXE_SH: begin
        be_o   = addr_lo[1] ? 4'b1100 : 4'b0011;
        data_o = {2{data_i[15:0]}};
      end
      EXE_SW: begin
        be_o   = 4'b1111;
        data_o = data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage / load-store unit of the bittyCore pipeline.
// Aligned loads/stores run a req/ack bus transaction while holding the
// pipeline with stallreq_o; misaligned ones are flagged without touching
// the bus; all other ops pass straight through to mem_wb.
// Ports:
//   ex_mem side : mem_aluop_i, mem_addr_i, mem_reg2_i, wd_i, wreg_i, wdata_i
//   mem_wb side : wd_o, wreg_o, wdata_o
//   control     : stallreq_o, misalign_o (1 cycle), err_o (1 cycle)
//   data bus    : bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
//                 bus_ack_i, bus_err_i, bus_rdata_i
//   debug       : lsu_state_o (current FSM state)
// Bus handshake: bus_req_o and every bus field are registered and held
// constant from the first BUSY cycle until the slave raises bus_ack_i or
// bus_err_i (sampled on the clock edge); bus_req_o drops on that same edge.
// bus_err_i takes priority over bus_ack_i; the transfer is abandoned when
// TIMEOUT BUSY cycles pass without a response.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] mem_aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_reg2_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               stallreq_o,
  output logic               misalign_o,
  output logic               err_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [31:0]        bus_addr_o,
  output logic [BUS_BE_W-1:0] bus_be_o,
  output logic [31:0]        bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic               bus_err_i,
  input  logic [31:0]        bus_rdata_i,
  output lsu_state_e         lsu_state_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e          state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         rdata_q;

  logic [7:0]          op;
  logic                is_load, is_store, misaligned, start;
  logic [BUS_BE_W-1:0] st_be, ld_be, req_be;
  logic [31:0]         st_data, ld_data;

  assign op         = 8'(mem_aluop_i);
  assign is_load    = is_load_op(op);
  assign is_store   = is_store_op(op);
  assign misaligned = is_misaligned(op, mem_addr_i[1:0]);
  assign start      = (state == LSU_IDLE) && (is_load || is_store) && !misaligned;
  assign req_be     = is_store ? st_be : ld_be;
  assign lsu_state_o = state;

  // Store path works on rs2; load path works on the captured read word.
  // ex_mem holds aluop/addr stable until DONE, so the load path can use
  // the live inputs when formatting.
  mem_lsu_align u_align_st (
    .op      (op),
    .addr_lo (mem_addr_i[1:0]),
    .data_i  (mem_reg2_i),
    .be_o    (st_be),
    .data_o  (st_data)
  );

  mem_lsu_align u_align_ld (
    .op      (op),
    .addr_lo (mem_addr_i[1:0]),
    .data_i  (rdata_q),
    .be_o    (ld_be),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_be_o    <= req_be;
            bus_wdata_o <= is_store ? st_data : 32'd0;
            cnt         <= '0;
          end
        end
        LSU_BUSY: begin
          cnt <= cnt + 1'b1;
          if (state_d != LSU_BUSY) bus_req_o <= 1'b0;
          if (state_d == LSU_DONE) rdata_q <= bus_rdata_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    err_o      = 1'b0;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    case (state)
      LSU_IDLE: begin
        if (is_load || is_store) begin
          wreg_o = 1'b0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            state_d    = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (bus_err_i)                       state_d = LSU_ABORT;
        else if (bus_ack_i)                  state_d = LSU_DONE;
        else if (cnt == CNT_LAST)            state_d = LSU_ABORT;
      end
      LSU_DONE: begin
        wdata_o = ld_data;
        wreg_o  = is_load ? wreg_i : 1'b0;
        state_d = LSU_IDLE;
      end
      LSU_ABORT: begin
        err_o   = 1'b1;
        wreg_o  = 1'b0;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (rst) begin
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      err_o      = 1'b0;
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
    end
  end

endmodule
